alu_seq_unit: RTL and testbench
===============================

# alu_seq_unit

Parametrised execute unit that succeeds the combinational ALU controller. It decodes ALUOp/Funct7/Funct3 into a 4-bit operation, executes base RV integer ops in one cycle, and optionally runs M-extension multiply/divide over multiple cycles. It sits between the decode stage and writeback behind a valid/ready handshake, so the pipeline can stall on long operations.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden).
- clk  in  1  rising-edge clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts when in_valid && in_ready.
- alu_op  in  3  ALUOp from the main controller.
- funct7  in  7  instruction funct7.
- funct3  in  3  instruction funct3.
- op_a, op_b  in  XLEN each  operands (rs1, rs2/imm).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result when out_valid && out_ready.
- result  out  XLEN  registered result.
- zero  out  1  result == 0, registered with result.
- illegal  out  1  accepted op did not decode; result forced to 0.
- operation  out  4  decoded op code of the result currently held.

## Operation
- Op codes: AND 0000, OR 0001, ADD 0010, SLL 0011, REM 0100, REMU 0101, SUB 0110, SLT 0111, SRL 1000, SLTU 1001, SRA 1010, XOR 1100, MUL 1101, DIV 1110, DIVU 1111. Code 1011 is unused.
- Decode by alu_op:
  - 000 → ADD.
  - 001 → SUB.
  - 010 (R-type) → funct3 plus funct7. 0000000 gives base ops; 0100000 with funct3 000/101 gives SUB/SRA; 0000001 gives M ops (000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU); anything else is illegal.
  - 011 (I-type) → funct3 only, except 101, where funct7[5] selects SRA; funct3 001/101 with any other funct7 bit set is illegal.
  - 1xx → illegal.
  - MULH* (R-type, funct7 0000001, funct3 001/010/011) is illegal.
- Arithmetic:
  - Wrap-around modulo 2^XLEN.
  - Shifts use op_b[SHW-1:0].
  - SLT is signed; SLTU is unsigned. Both give 0 or 1.
  - MUL returns the low XLEN bits of the product.
- Divide by zero: DIV/DIVU → all ones; REM/REMU → op_a.
- Signed overflow (op_a = most-negative, op_b = −1): DIV → op_a; REM → 0.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: accept → DONE for single-cycle, illegal or special-case divide; → MUL for MUL; → DIV otherwise.
  - MUL: one cycle → DONE.
  - DIV: restoring radix-2 iteration with counter XLEN-1..0 → DONE when counter is 0. Signed ops divide magnitudes and fix the sign on exit. Remainder takes the sign of the dividend.
  - DONE: out_valid=1. On out_ready → IDLE, or accept a new op in the same cycle if in_valid.
- in_ready = !reset && (state==IDLE || (state==DONE && out_ready)).
- result, zero, illegal and operation are stable while out_valid && !out_ready.

## Timing
- Reset outputs: state IDLE, out_valid 0, result 0, zero 1, illegal 0, operation 0000; in_ready 0 while reset is high, 1 the cycle after.
- Accept at edge N gives out_valid at:
  - single-cycle, illegal or divide special case: N+1;
  - MUL: N+2;
  - DIV/DIVU/REM/REMU: N+XLEN+1.
- Back-to-back single-cycle ops with out_ready held high: one result per cycle.
- Reset asserted mid-MUL/DIV: the op is aborted, no out_valid is produced, and the next state is IDLE.
- in_valid while busy is ignored. The upstream stage must hold its operands until in_ready is high.

## Configuration
- ALU_SEQ_MDU_EN defined: M ops are decoded and executed as above; the MUL and DIV states exist.
- ALU_SEQ_MDU_EN undefined: funct7 0000001 in R-type is illegal (result 0, latency 1). The MUL/DIV states, the multiplier and the divider are not synthesised.

## Structure
- Package alu_seq_pkg holds the 4-bit op-code localparams, the ALUOp class constants (000/001/010/011) and the FSM state enum.
- Sub-module alu_seq_divider holds the iterative XLEN-cycle divider (start/busy/done, quotient and remainder). It is instantiated only under ALU_SEQ_MDU_EN.

## Test plan
- Reset, then R-type ADD 5+7 and SUB 5−7 back-to-back with out_ready=1 → result 12 then 0xFFFFFFFE, each 1 cycle after accept; zero=0.
- I-type SRAI: op_a=0x80000000, op_b=4, funct7=0100000 → 0xF8000000. Same op with funct7=0000000 (SRLI) → 0x08000000. alu_op=100 → illegal=1, result 0.
- MUL 0xFFFFFFFF×3 → 0xFFFFFFFD, out_valid exactly 2 cycles after accept. Hold out_ready=0 for 3 cycles → result stable and in_ready=0.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; each out_valid at N+33 (XLEN=32).
- DIVU 9/0 → 0xFFFFFFFF; REM 0x80000000/−1 → 0; both at N+1.
- Assert reset at cycle 10 of a DIV → no out_valid, in_ready=1 the cycle after reset drops. Build without ALU_SEQ_MDU_EN → MUL accept gives illegal=1 at N+1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, ALUOp classes, FSM states and decode helpers shared by alu_seq_unit.
package alu_seq_pkg;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_REM  = 4'b0100;
  localparam logic [3:0] OP_REMU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;
  localparam logic [3:0] OP_DIV  = 4'b1110;
  localparam logic [3:0] OP_DIVU = 4'b1111;
  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_R   = 3'b010;
  localparam logic [2:0] ALUOP_I   = 3'b011;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction
  function automatic logic [3:0] mdu_op(input logic [2:0] f3);
    return f3 == 3'b000 ? OP_MUL : f3 == 3'b100 ? OP_DIV : f3 == 3'b101 ? OP_DIVU :
           f3 == 3'b110 ? OP_REM : OP_REMU;
  endfunction
endpackage

// File: rtl/alu_seq_divider.sv
// alu_seq_divider: restoring radix-2 unsigned divider, one quotient bit per cycle over XLEN cycles.
module alu_seq_divider
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] q,
  output logic [XLEN-1:0] r
);
  localparam int CW = $clog2(XLEN);
  logic [XLEN-1:0] quo, rem;
  logic [CW-1:0] cnt;
  logic [XLEN:0] sh, diff;
  assign sh = {rem, quo[XLEN-1]};
  assign diff = sh - {1'b0, b};
  // q/r are the values after the current step, so the final step is visible as done rises
  assign q = {quo[XLEN-2:0], !diff[XLEN]};
  assign r = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
  assign done = busy && cnt == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= CW'(XLEN - 1);
      quo <= a;
      rem <= '0;
    end else if (busy) begin
      busy <= !done;
      cnt <= cnt - 1'b1;
      quo <= q;
      rem <= r;
    end
  end
endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: ALU decode/execute behind valid/ready; multi-cycle MUL/DIV/REM only with `ALU_SEQ_MDU_EN.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic [3:0]      operation
);
  localparam int SHW = $clog2(XLEN);
  state_e state, state_n, acc_st;
  logic [3:0] dop;
  logic dill, acc;
  logic [XLEN-1:0] alu_y, y;
  logic [SHW-1:0] sh;
  assign sh = op_b[SHW-1:0];
  assign in_ready = !reset && (state == S_IDLE || (state == S_DONE && out_ready));
  assign acc = in_valid && in_ready;
  assign out_valid = state == S_DONE;
  always_comb begin
    dop = OP_ADD;
    dill = 1'b0;
    case (alu_op)
      ALUOP_ADD: dop = OP_ADD;
      ALUOP_SUB: dop = OP_SUB;
      ALUOP_R: begin
        if (funct7 == 7'b0000000) dop = base_op(funct3);
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) dop = OP_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) dop = OP_SRA;
`ifdef ALU_SEQ_MDU_EN
        else if (funct7 == 7'b0000001 && (funct3 == 3'b000 || funct3[2])) dop = mdu_op(funct3);
`endif
        else dill = 1'b1;
      end
      ALUOP_I: begin
        dop = (funct3 == 3'b101 && funct7[5]) ? OP_SRA : base_op(funct3);
        dill = funct3[1:0] == 2'b01 && (funct7 & 7'b1011111) != 7'b0;
      end
      default: dill = 1'b1;
    endcase
  end
  always_comb begin
    case (dop)
      OP_AND:  alu_y = op_a & op_b;
      OP_OR:   alu_y = op_a | op_b;
      OP_ADD:  alu_y = op_a + op_b;
      OP_SUB:  alu_y = op_a - op_b;
      OP_XOR:  alu_y = op_a ^ op_b;
      OP_SLL:  alu_y = op_a << sh;
      OP_SRL:  alu_y = op_a >> sh;
      OP_SRA:  alu_y = $signed(op_a) >>> sh;
      OP_SLT:  alu_y = XLEN'($signed(op_a) < $signed(op_b));
      OP_SLTU: alu_y = XLEN'(op_a < op_b);
      default: alu_y = '0;
    endcase
  end
`ifdef ALU_SEQ_MDU_EN
  logic [XLEN-1:0] ma, mb, da, db, dq, dr, sp_y, mdu_y;
  logic sgn, is_rem, is_div, bz, ovf, div_sp, neg_q, neg_r, rem_sel, dv_busy, dv_done, go_mul, go_div;
  assign sgn = dop == OP_DIV || dop == OP_REM;
  assign is_rem = dop == OP_REM || dop == OP_REMU;
  assign is_div = sgn || dop == OP_DIVU || dop == OP_REMU;
  assign bz = op_b == '0;
  assign ovf = sgn && op_a == {1'b1, {(XLEN-1){1'b0}}} && &op_b;
  // divide-by-zero and signed overflow resolve in one cycle without the divider
  assign div_sp = is_div && (bz || ovf);
  assign sp_y = bz ? (is_rem ? op_a : '1) : (is_rem ? '0 : op_a);
  assign go_mul = !dill && dop == OP_MUL;
  assign go_div = !dill && is_div && !div_sp;
  assign acc_st = go_mul ? S_MUL : go_div ? S_DIV : S_DONE;
  assign da = (sgn && op_a[XLEN-1]) ? -op_a : op_a;
  assign db = (sgn && op_b[XLEN-1]) ? -op_b : op_b;
  assign y = dill ? '0 : div_sp ? sp_y : alu_y;
  assign mdu_y = state == S_MUL ? ma * mb : rem_sel ? (neg_r ? -dr : dr) : (neg_q ? -dq : dq);
  always_ff @(posedge clk) begin
    if (acc) begin
      ma <= op_a;
      mb <= op_b;
      neg_q <= sgn && (op_a[XLEN-1] ^ op_b[XLEN-1]);
      neg_r <= sgn && op_a[XLEN-1];
      rem_sel <= is_rem;
    end
  end
  alu_seq_divider #(.XLEN(XLEN)) u_div (
    .clk(clk), .rst(reset), .start(acc && go_div), .a(da), .b(db),
    .busy(dv_busy), .done(dv_done), .q(dq), .r(dr)
  );
`else
  assign acc_st = S_DONE;
  assign y = dill ? '0 : alu_y;
`endif
  always_ff @(posedge clk) state <= reset ? S_IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: state_n = acc ? acc_st : (state == S_DONE && out_ready) ? S_IDLE : state;
`ifdef ALU_SEQ_MDU_EN
      S_MUL: state_n = S_DONE;
      S_DIV: state_n = dv_done ? S_DONE : dv_busy ? S_DIV : S_IDLE;
`endif
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      zero <= 1'b1;
      illegal <= 1'b0;
      operation <= OP_AND;
    end else if (acc) begin
      result <= y;
      zero <= (y == '0);
      illegal <= dill;
      operation <= dill ? OP_AND : dop;
`ifdef ALU_SEQ_MDU_EN
    end else if (state == S_MUL || dv_done) begin
      result <= mdu_y;
      zero <= (mdu_y == '0);
`endif
    end
  end
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: scoreboard bench for alu_seq_unit; expectations follow whether ALU_SEQ_MDU_EN is defined.
module tb_alu_seq_unit;
  import alu_seq_pkg::*;
`ifdef ALU_SEQ_MDU_EN
  localparam bit M = 1'b1;
`else
  localparam bit M = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0] alu_op = '0, funct3 = '0;
  logic [6:0] funct7 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic in_ready, out_valid, zero, illegal;
  logic [31:0] result;
  logic [3:0] operation;
  int total = 0, bad = 0, cyc = 0;
  bit seen = 1'b0;
  typedef struct {
    string nm;
    logic [31:0] y;
    logic ill;
    logic [3:0] op;
    int lat;
    int acc;
  } ent_t;
  ent_t sb[$];
  ent_t me;

  alu_seq_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .illegal(illegal), .operation(operation)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) seen = 1'b0;
    else begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          me = sb[0];
          chk({me.nm, ".result"}, result, me.y);
          chk({me.nm, ".zero"}, zero, me.y == 0);
          chk({me.nm, ".illegal"}, illegal, me.ill);
          if (!me.ill) chk({me.nm, ".operation"}, operation, me.op);
          chk({me.nm, ".latency"}, cyc - me.acc + 1, me.lat);
        end
      end
      if (out_valid && out_ready) begin
        seen = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
      end
    end
  end

  task automatic issue(input string nm, input logic [2:0] ao, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] y,
                       input logic ill, input logic [3:0] op, input int lat);
    int w = 0;
    ent_t e;
    alu_op = ao; funct7 = f7; funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
    #1;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk({nm, ".accept"}, in_ready, 1);
    if (in_ready) begin
      e.nm = nm; e.y = y; e.ill = ill; e.op = op; e.lat = lat; e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() > 0 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, nv;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.result", result, 0);
    chk("rst.zero", zero, 1);
    chk("rst.illegal", illegal, 0);
    chk("rst.operation", operation, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst.in_ready_after", in_ready, 1);
    @(posedge clk); #1;
    issue("add",     3'b010, 7'h00, 3'b000, 5, 7, 12, 0, OP_ADD, 1);
    issue("sub",     3'b010, 7'h20, 3'b000, 5, 7, 32'hFFFFFFFE, 0, OP_SUB, 1);
    issue("srai",    3'b011, 7'h20, 3'b101, 32'h80000000, 4, 32'hF8000000, 0, OP_SRA, 1);
    issue("srli",    3'b011, 7'h00, 3'b101, 32'h80000000, 4, 32'h08000000, 0, OP_SRL, 1);
    issue("ill_aop", 3'b100, 7'h00, 3'b000, 1, 2, 0, 1, OP_AND, 1);
    issue("addz",    3'b000, 7'h7F, 3'b111, 32'hFFFFFFFF, 1, 0, 0, OP_ADD, 1);
    issue("subz",    3'b001, 7'h00, 3'b100, 3, 3, 0, 0, OP_SUB, 1);
    issue("slti",    3'b011, 7'h00, 3'b010, 32'hFFFFFFFF, 1, 1, 0, OP_SLT, 1);
    issue("sltiu",   3'b011, 7'h00, 3'b011, 32'hFFFFFFFF, 1, 0, 0, OP_SLTU, 1);
    issue("xor",     3'b010, 7'h00, 3'b100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 0, OP_XOR, 1);
    issue("sll33",   3'b010, 7'h00, 3'b001, 1, 33, 2, 0, OP_SLL, 1);
    issue("and",     3'b010, 7'h00, 3'b111, 12, 10, 8, 0, OP_AND, 1);
    issue("or",      3'b010, 7'h00, 3'b110, 12, 10, 14, 0, OP_OR, 1);
    issue("sra",     3'b010, 7'h20, 3'b101, 32'hFFFFFFF0, 2, 32'hFFFFFFFC, 0, OP_SRA, 1);
    issue("slli_bad", 3'b011, 7'h01, 3'b001, 1, 1, 0, 1, OP_AND, 1);
    issue("r_bad",   3'b010, 7'h20, 3'b100, 1, 1, 0, 1, OP_AND, 1);
    issue("mulh",    3'b010, 7'h01, 3'b001, 2, 3, 0, 1, OP_AND, 1);
    drain();
    issue("mul",    3'b010, 7'h01, 3'b000, 32'hFFFFFFFF, 3, M ? 32'hFFFFFFFD : 0, !M, OP_MUL, M ? 2 : 1);
    issue("div",    3'b010, 7'h01, 3'b100, 32'hFFFFFFF9, 2, M ? 32'hFFFFFFFD : 0, !M, OP_DIV, M ? 33 : 1);
    issue("rem",    3'b010, 7'h01, 3'b110, 32'hFFFFFFF9, 2, M ? 32'hFFFFFFFF : 0, !M, OP_REM, M ? 33 : 1);
    issue("divu0",  3'b010, 7'h01, 3'b101, 9, 0, M ? 32'hFFFFFFFF : 0, !M, OP_DIVU, 1);
    issue("removf", 3'b010, 7'h01, 3'b110, 32'h80000000, 32'hFFFFFFFF, 0, !M, OP_REM, 1);
    issue("divovf", 3'b010, 7'h01, 3'b100, 32'h80000000, 32'hFFFFFFFF, M ? 32'h80000000 : 0, !M, OP_DIV, 1);
    issue("remu0",  3'b010, 7'h01, 3'b111, 32'h1234, 0, M ? 32'h1234 : 0, !M, OP_REMU, 1);
    issue("divu",   3'b010, 7'h01, 3'b101, 100, 7, M ? 14 : 0, !M, OP_DIVU, M ? 33 : 1);
    drain();
    out_ready = 1'b0;
    issue("mul_hold", 3'b010, 7'h01, 3'b000, 32'hFFFFFFFF, 3, M ? 32'hFFFFFFFD : 0, !M, OP_MUL, M ? 2 : 1);
    w = 0;
    while (!out_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("hold.valid", out_valid, 1);
    repeat (3) begin
      @(negedge clk);
      chk("hold.result", result, M ? 32'hFFFFFFFD : 0);
      chk("hold.in_ready", in_ready, 0);
      chk("hold.out_valid", out_valid, 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    drain();
    issue("div_abort", 3'b010, 7'h01, 3'b100, 100, 7, M ? 14 : 0, !M, OP_DIV, M ? 33 : 1);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort.in_ready", in_ready, 0);
    chk("abort.pending", sb.size(), M ? 1 : 0);
    sb.delete();
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort.in_ready_after", in_ready, 1);
    nv = 0;
    repeat (40) begin
      if (out_valid) nv++;
      @(negedge clk);
    end
    chk("abort.no_valid", nv, 0);
    @(posedge clk); #1;
    issue("post_add", 3'b000, 7'h00, 3'b000, 1, 1, 2, 0, OP_ADD, 1);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
